seg7_scan_capture: RTL and testbench

- Receive-side monitor for the board's multiplexed 7-segment display bus.
- Samples the anode and segment lines a display driver produces, waits for each scan slot to settle, and decodes each segment pattern back to BCD.
- Keeps one BCD register per digit position, with per-digit valid status and error and update pulses.
- Used as a loop-back checker for display drivers in simulation and on hardware.

---
 rtl/seg7_scan_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: synchronizes anode/segment
// lines, waits for each scan slot to settle, and decodes the pattern back to BCD per digit.
module seg7_scan_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  an_in,
   input  logic [6:0]  seg_in,
   output logic [31:0] digits,
   output logic [7:0]  valid,
   output logic        update,
   output logic [2:0]  update_idx,
   output logic        change,
   output logic        err_pattern,
   output logic        err_anode
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic [0:0] {ST_WAIT = 1'b0, ST_HOLD = 1'b1} state_t;

   // Returns {is_digit, is_blank, nibble} for an active-low {g..a} pattern.
   function automatic logic [5:0] decode_seg(input logic [6:0] seg);
      logic [5:0] res;
      case (seg)
         7'h40:   res = 6'b10_0000;
         7'h79:   res = 6'b10_0001;
         7'h24:   res = 6'b10_0010;
         7'h30:   res = 6'b10_0011;
         7'h19:   res = 6'b10_0100;
         7'h12:   res = 6'b10_0101;
         7'h02:   res = 6'b10_0110;
         7'h78:   res = 6'b10_0111;
         7'h00:   res = 6'b10_1000;
         7'h10:   res = 6'b10_1001;
         7'h7F:   res = 6'b01_0000;
         default: res = 6'b00_0000;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] count_low(input logic [7:0] an);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (an[i] == 1'b0) begin
            n = n + 4'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   function automatic logic [2:0] low_index(input logic [7:0] an);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (an[i] == 1'b0) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [7:0]    an_meta_r, an_samp_r, an_prev_r;
   logic [6:0]    seg_meta_r, seg_samp_r, seg_prev_r;
   logic [CW-1:0] cnt_r;
   state_t        state_r;

   logic [31:0]   digits_r;
   logic [7:0]    valid_r;
   logic          update_r, change_r, err_pattern_r, err_anode_r;
   logic [2:0]    update_idx_r;

   logic          diff_s, accept_s;
   logic [3:0]    lows_s;
   logic [2:0]    idx_s;
   logic [5:0]    dec_s;
   logic [3:0]    old_nib_s;

   // Two-flop synchronizer plus previous-sample register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_meta_r  <= AN_OFF;
         seg_meta_r <= SEG_OFF;
         an_samp_r  <= AN_OFF;
         seg_samp_r <= SEG_OFF;
         an_prev_r  <= AN_OFF;
         seg_prev_r <= SEG_OFF;
      end else begin
         an_meta_r  <= an_in;
         seg_meta_r <= seg_in;
         an_samp_r  <= an_meta_r;
         seg_samp_r <= seg_meta_r;
         an_prev_r  <= an_samp_r;
         seg_prev_r <= seg_samp_r;
      end
   end

   // Sample classification and accept detection.
   always_comb begin
      diff_s    = 1'b0;
      accept_s  = 1'b0;
      lows_s    = count_low(an_samp_r);
      idx_s     = low_index(an_samp_r);
      dec_s     = decode_seg(seg_samp_r);
      old_nib_s = digits_r[{idx_s, 2'b00} +: 4];
      if ({an_samp_r, seg_samp_r} != {an_prev_r, seg_prev_r}) begin
         diff_s = 1'b1;
      end else begin
         diff_s = 1'b0;
      end
      if ((state_r == ST_WAIT) && !diff_s && (cnt_r == CNT_LAST)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Stability counter and WAIT/HOLD window FSM; one accept per stable window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         state_r <= ST_WAIT;
      end else begin
         case (state_r)
            ST_WAIT: begin
               if (diff_s) begin
                  cnt_r <= '0;
               end else if (cnt_r < CNT_MAX) begin
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == CNT_LAST) begin
                     state_r <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (diff_s) begin
                  cnt_r   <= '0;
                  state_r <= ST_WAIT;
               end
            end
            default: begin
               cnt_r   <= '0;
               state_r <= ST_WAIT;
            end
         endcase
      end
   end

   // Digit registers, valid flags and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_r      <= 32'd0;
         valid_r       <= 8'd0;
         update_r      <= 1'b0;
         update_idx_r  <= 3'd0;
         change_r      <= 1'b0;
         err_pattern_r <= 1'b0;
         err_anode_r   <= 1'b0;
      end else begin
         update_r      <= 1'b0;
         change_r      <= 1'b0;
         err_pattern_r <= 1'b0;
         err_anode_r   <= 1'b0;
         if (accept_s && (lows_s == 4'd1)) begin
            update_r     <= 1'b1;
            update_idx_r <= idx_s;
            if (dec_s[5]) begin
               digits_r[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
               valid_r[idx_s]                <= 1'b1;
               change_r                      <= (old_nib_s != dec_s[3:0]);
            end else if (dec_s[4]) begin
               valid_r[idx_s] <= 1'b0;
            end else begin
               valid_r[idx_s] <= 1'b0;
               err_pattern_r  <= 1'b1;
            end
         end else if (accept_s && (lows_s >= 4'd2)) begin
            err_anode_r <= 1'b1;
         end
      end
   end

   assign digits      = digits_r;
   assign valid       = valid_r;
   assign update      = update_r;
   assign update_idx  = update_idx_r;
   assign change      = change_r;
   assign err_pattern = err_pattern_r;
   assign err_anode   = err_anode_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized bench for seg7_scan_capture against a run-length reference model
// of the bus (two-cycle sample delay, accept when a value has been seen STABLE+1 times).
module tb_seg7_scan_capture;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  an_in = 8'hFF;
   logic [6:0]  seg_in = 7'h7F;
   logic [31:0] digits;
   logic [7:0]  valid;
   logic        update, change, err_pattern, err_anode;
   logic [2:0]  update_idx;

   int total = 0;
   int bad = 0;

   seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .an_in(an_in), .seg_in(seg_in),
      .digits(digits), .valid(valid), .update(update), .update_idx(update_idx),
      .change(change), .err_pattern(err_pattern), .err_anode(err_anode)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Reference model state
   logic [14:0] pipe [$];
   logic [14:0] last_v;
   int          run;
   logic [3:0]  m_dig [8];
   logic        m_val [8];
   logic        m_upd, m_chg, m_errp, m_erra;
   logic [2:0]  m_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe = {15'h7FFF, 15'h7FFF};
         last_v = 15'h7FFF;
         run = 1;
         for (int i = 0; i < 8; i++) begin m_dig[i] = 4'd0; m_val[i] = 1'b0; end
         m_upd = 0; m_chg = 0; m_errp = 0; m_erra = 0; m_idx = 3'd0;
      end else begin
         logic [14:0] t;
         int nlow, idx, d;
         t = pipe.pop_front();
         pipe.push_back({an_in, seg_in});
         if (t == last_v) begin
            if (run < 1000) run++;
         end else begin
            run = 1;
            last_v = t;
         end
         m_upd = 0; m_chg = 0; m_errp = 0; m_erra = 0;
         if (run == STABLE + 1) begin
            nlow = 0; idx = 0;
            for (int i = 0; i < 8; i++) if (!t[7+i]) begin nlow++; idx = i; end
            if (nlow == 1) begin
               d = -1;
               for (int k = 0; k < 10; k++) if (seg_tab[k] == t[6:0]) d = k;
               m_upd = 1;
               m_idx = 3'(idx);
               if (d >= 0) begin
                  m_chg = (m_dig[idx] != 4'(d));
                  m_dig[idx] = 4'(d);
                  m_val[idx] = 1'b1;
               end else begin
                  m_val[idx] = 1'b0;
                  m_errp = (t[6:0] != 7'h7F);
               end
            end else if (nlow >= 2) begin
               m_erra = 1;
            end
         end
      end
   end

   int n_upd = 0, n_chg = 0, n_errp = 0, n_erra = 0;

   // Cycle-by-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (rst_n) begin
         logic [31:0] ed;
         logic [7:0]  ev;
         for (int i = 0; i < 8; i++) begin ed[4*i +: 4] = m_dig[i]; ev[i] = m_val[i]; end
         check_eq("digits", digits, ed);
         check_eq("valid", {24'd0, valid}, {24'd0, ev});
         check_eq("update", {31'd0, update}, {31'd0, m_upd});
         check_eq("update_idx", {29'd0, update_idx}, {29'd0, m_idx});
         check_eq("change", {31'd0, change}, {31'd0, m_chg});
         check_eq("err_pattern", {31'd0, err_pattern}, {31'd0, m_errp});
         check_eq("err_anode", {31'd0, err_anode}, {31'd0, m_erra});
         n_upd += int'(update);
         n_chg += int'(change);
         n_errp += int'(err_pattern);
         n_erra += int'(err_anode);
      end
   end

   task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
      an_in = an;
      seg_in = seg;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int u0, c0, e0;
      @(negedge clk);
      check_eq("rst_digits", digits, 32'd0);
      check_eq("rst_valid", {24'd0, valid}, 32'd0);
      check_eq("rst_pulses", {28'd0, update, change, err_pattern, err_anode}, 32'd0);
      check_eq("rst_idx", {29'd0, update_idx}, 32'd0);
      rst_n = 1'b1;
      hold(8'hFF, 7'h7F, 10);
      check_eq("idle_no_update", 32'(n_upd), 32'd0);

      // 1: digit 0 shows 5 then 9
      u0 = n_upd; c0 = n_chg;
      hold(8'hFE, 7'h12, 20);
      check_eq("t1_digit5", {28'd0, digits[3:0]}, 32'd5);
      hold(8'hFE, 7'h10, 20);
      check_eq("t1_digit9", {28'd0, digits[3:0]}, 32'd9);
      check_eq("t1_valid0", {31'd0, valid[0]}, 32'd1);
      check_eq("t1_updates", 32'(n_upd - u0), 32'd2);
      check_eq("t1_changes", 32'(n_chg - c0), 32'd2);

      // 2: digit 3 window, no re-accept, blank gap, re-present
      u0 = n_upd; c0 = n_chg;
      hold(8'hF7, 7'h30, 20);
      check_eq("t2_one_update", 32'(n_upd - u0), 32'd1);
      hold(8'hF7, 7'h7F, 10);
      u0 = n_upd; c0 = n_chg;
      hold(8'hF7, 7'h30, 10);
      check_eq("t2_reupdate", 32'(n_upd - u0), 32'd1);
      check_eq("t2_nochange", 32'(n_chg - c0), 32'd0);

      // 3: blank on digit 2
      e0 = n_errp;
      hold(8'hFB, 7'h7F, 10);
      check_eq("t3_valid2", {31'd0, valid[2]}, 32'd0);
      check_eq("t3_noerr", 32'(n_errp - e0), 32'd0);

      // 4: bad pattern, then two anodes low
      hold(8'hFE, 7'h55, 10);
      check_eq("t4_errp", 32'(n_errp - e0), 32'd1);
      check_eq("t4_nibble_kept", {28'd0, digits[3:0]}, 32'd9);
      e0 = n_erra;
      hold(8'hFC, 7'h12, 10);
      check_eq("t4_erra", 32'(n_erra - e0), 32'd1);

      // 5: toggling too fast to ever settle
      hold(8'hFE, 7'h10, 10);
      u0 = n_upd;
      for (int i = 0; i < 20; i++) hold(8'hFE, (i % 2 == 0) ? 7'h12 : 7'h10, 3);
      check_eq("t5_no_update", 32'(n_upd - u0), 32'd0);

      // 6: reset mid-window on digit 7
      hold(8'h7F, 7'h00, 3);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_digits", digits, 32'd0);
      check_eq("t6_rst_valid", {24'd0, valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      u0 = n_upd;
      hold(8'h7F, 7'h00, 12);
      check_eq("t6_one_update", 32'(n_upd - u0), 32'd1);
      check_eq("t6_digit7", {28'd0, digits[31:28]}, 32'd8);

      // Random scans
      for (int r = 0; r < 300; r++) begin
         logic [7:0] an;
         logic [6:0] seg;
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel == 0) an = 8'hFF;
         else if (sel == 1) an = 8'($urandom) & 8'($urandom);
         else an = ~(8'd1 << $urandom_range(0, 7));
         sel = int'($urandom_range(0, 9));
         if (sel == 0) seg = 7'h7F;
         else if (sel == 1) seg = 7'($urandom);
         else seg = seg_tab[$urandom_range(0, 9)];
         hold(an, seg, int'($urandom_range(1, 12)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
